// File: rtl/gondola_tx_buffer.sv
// gondola_tx_buffer: word FIFO feeding a parallel-to-serial shifter.
// Words are queued through wr_valid/wr_ready and sent one bit per cycle
// while tx_en is high. bits_used tracks every bit not yet sent, counting
// both the FIFO contents and the bits still waiting in the shift register.
module gondola_tx_buffer #(
   parameter  int DATA_W    = 8,
   parameter  int DEPTH     = 128,
   parameter  int LSB_FIRST = 1,
   localparam int BW        = $clog2(DEPTH*DATA_W + DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              tx_en,
   output logic              tx_bit,
   output logic              tx_bit_valid,
   output logic [BW-1:0]     bits_used,
   output logic              empty,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW = $clog2(DATA_W);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PAUSE} state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     sel;

   logic wr_fire;
   logic consume;
   logic last_bit;
   logic have_word;
   logic pop;

   assign wr_ready  = (count < CW'(DEPTH));
   assign wr_fire   = wr_valid && wr_ready;
   assign have_word = (count != '0);
   assign last_bit  = (idx == IW'(DATA_W - 1));
   // A bit is only consumed while shifting with the enable high; a SHIFT
   // cycle with tx_en low just moves to PAUSE, so it is not flagged valid.
   assign consume   = (state == SHIFT) && tx_en;
   // The FIFO head leaves either in LOAD or back-to-back on the last bit.
   assign pop       = (state == LOAD) || (consume && last_bit && have_word);

   assign sel          = (LSB_FIRST != 0) ? idx : (IW'(DATA_W - 1) - idx);
   assign tx_bit       = shreg[sel];
   assign tx_bit_valid = consume;
   assign empty        = (bits_used == '0);

   // Storage array: write port only, no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers and word count; push and pop may share an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_fire, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Unsent-bit counter: +DATA_W per accepted word, -1 per consumed bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bits_used <= '0;
      end else begin
         case ({wr_fire, consume})
            2'b10:   bits_used <= bits_used + BW'(DATA_W);
            2'b01:   bits_used <= bits_used - BW'(1);
            2'b11:   bits_used <= bits_used + BW'(DATA_W - 1);
            default: bits_used <= bits_used;
         endcase
      end
   end

   // Sticky overflow on a dropped write; a new drop beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_valid && !wr_ready) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   // Serialiser control: loads words from the FIFO head and walks the bit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (tx_en && have_word) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               shreg <= mem[rd_ptr];
               idx   <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               if (!tx_en) begin
                  state <= PAUSE;
               end else if (last_bit) begin
                  idx <= '0;
                  if (have_word) begin
                     shreg <= mem[rd_ptr];
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            PAUSE: begin
               if (tx_en) begin
                  state <= SHIFT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gondola_tx_buffer.sv
// Bench for gondola_tx_buffer: two instances (LSB-first and MSB-first),
// each with an expected-bit queue filled at write time and drained by a
// monitor whenever the instance flags a valid serial bit.
module tb_gondola_tx_buffer;

   localparam int DW = 8;
   localparam int DP = 4;
   localparam int BW = $clog2(DP*DW + DW + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          a_wr_valid = 1'b0, a_tx_en = 1'b0, a_clr = 1'b0;
   logic [DW-1:0] a_wr_data = '0;
   logic          a_wr_ready, a_tx_bit, a_valid, a_empty, a_ovf;
   logic [BW-1:0] a_bu;

   logic          b_wr_valid = 1'b0, b_tx_en = 1'b0, b_clr = 1'b0;
   logic [DW-1:0] b_wr_data = '0;
   logic          b_wr_ready, b_tx_bit, b_valid, b_empty, b_ovf;
   logic [BW-1:0] b_bu;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_bu = 0;

   logic q_a[$];
   logic q_b[$];

   always #5 clk = ~clk;

   gondola_tx_buffer #(.DATA_W(DW), .DEPTH(DP), .LSB_FIRST(1)) u_a (
      .clk(clk), .rst(rst),
      .wr_valid(a_wr_valid), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
      .tx_en(a_tx_en), .tx_bit(a_tx_bit), .tx_bit_valid(a_valid),
      .bits_used(a_bu), .empty(a_empty), .overflow(a_ovf), .clr_ovf(a_clr)
   );

   gondola_tx_buffer #(.DATA_W(DW), .DEPTH(DP), .LSB_FIRST(0)) u_b (
      .clk(clk), .rst(rst),
      .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
      .tx_en(b_tx_en), .tx_bit(b_tx_bit), .tx_bit_valid(b_valid),
      .bits_used(b_bu), .empty(b_empty), .overflow(b_ovf), .clr_ovf(b_clr)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; inputs are changed 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [DW-1:0] w);
      for (int i = 0; i < DW; i++) q_a.push_back(w[i]);
   endtask

   task automatic push_b(input logic [DW-1:0] w);
      for (int i = DW - 1; i >= 0; i--) q_b.push_back(w[i]);
   endtask

   // Monitor for the LSB-first instance.
   always @(negedge clk) begin
      if (a_valid === 1'b1) begin
         if (q_a.size() == 0) begin
            chk("mon_a_unexpected_bit", 1, 0);
         end else begin
            chk("mon_a_bit", int'(a_tx_bit), int'(q_a.pop_front()));
         end
      end
   end

   // Monitor for the MSB-first instance.
   always @(negedge clk) begin
      if (b_valid === 1'b1) begin
         if (q_b.size() == 0) begin
            chk("mon_b_unexpected_bit", 1, 0);
         end else begin
            chk("mon_b_bit", int'(b_tx_bit), int'(q_b.pop_front()));
         end
      end
   end

   initial begin
      logic [DW-1:0] words [4];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

      // Reset values while rst is held
      repeat (3) cyc();
      chk("rst_wr_ready", a_wr_ready, 1);
      chk("rst_empty", a_empty, 1);
      chk("rst_tx_bit", a_tx_bit, 0);
      chk("rst_tx_bit_valid", a_valid, 0);
      chk("rst_bits_used", a_bu, 0);
      chk("rst_overflow", a_ovf, 0);
      rst = 1'b0;
      cyc();

      // Single word A5, LSB first, with IDLE -> LOAD -> SHIFT latency
      a_tx_en = 1'b1;
      a_wr_valid = 1'b1; a_wr_data = 8'hA5; push_a(8'hA5);
      cyc();
      a_wr_valid = 1'b0;
      chk("t1_bu_after_write", a_bu, 8);
      chk("t1_valid_edge1", a_valid, 0);
      cyc();
      chk("t1_valid_load", a_valid, 0);
      cyc();
      for (int i = 0; i < 8; i++) begin
         chk("t1_valid", a_valid, 1);
         chk("t1_bits_used", a_bu, 8 - i);
         cyc();
      end
      chk("t1_end_valid", a_valid, 0);
      chk("t1_end_empty", a_empty, 1);
      chk("t1_end_bu", a_bu, 0);

      // Fill to DEPTH with tx_en low, then overflow and clear
      a_tx_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a_wr_valid = 1'b1; a_wr_data = words[k]; push_a(words[k]);
         cyc();
      end
      a_wr_valid = 1'b0;
      chk("t2_full_wr_ready", a_wr_ready, 0);
      chk("t2_full_bu", a_bu, 32);
      a_wr_valid = 1'b1; a_wr_data = 8'h55;
      cyc();
      a_wr_valid = 1'b0;
      chk("t2_ovf_set", a_ovf, 1);
      chk("t2_drop_bu", a_bu, 32);
      a_clr = 1'b1; cyc(); a_clr = 1'b0;
      chk("t2_ovf_clr", a_ovf, 0);
      a_wr_valid = 1'b1; a_clr = 1'b1; a_wr_data = 8'h56;
      cyc();
      a_wr_valid = 1'b0; a_clr = 1'b0;
      chk("t2_set_beats_clr", a_ovf, 1);
      a_clr = 1'b1; cyc(); a_clr = 1'b0;
      chk("t2_ovf_clr2", a_ovf, 0);

      // Drain with back-to-back words, a write on a shift cycle and a
      // refused write on the pop edge of a full FIFO
      exp_bu = 32;
      a_tx_en = 1'b1;
      cyc();
      chk("t3_valid_load", a_valid, 0);
      cyc();
      for (int i = 0; i < 40; i++) begin
         chk("t3_valid", a_valid, 1);
         chk("t3_bits_used", a_bu, exp_bu);
         if (i == 0) begin
            chk("t3_wr_ready_shift", a_wr_ready, 1);
            a_wr_valid = 1'b1; a_wr_data = 8'h66; push_a(8'h66);
         end
         if (i == 7) begin
            chk("t3_full_on_pop", a_wr_ready, 0);
            a_wr_valid = 1'b1; a_wr_data = 8'h77;
         end
         cyc();
         a_wr_valid = 1'b0;
         exp_bu = exp_bu - 1;
         if (i == 0) begin
            exp_bu = exp_bu + 8;
            chk("t3_net_plus7", a_bu, 39);
         end
         if (i == 7) chk("t3_pop_edge_refused", a_ovf, 1);
      end
      chk("t3_end_valid", a_valid, 0);
      chk("t3_end_empty", a_empty, 1);

      // MSB-first pause/resume on F0
      b_tx_en = 1'b1;
      b_wr_valid = 1'b1; b_wr_data = 8'hF0; push_b(8'hF0);
      cyc();
      b_wr_valid = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk("t4_valid_pre", b_valid, 1);
         cyc();
      end
      b_tx_en = 1'b0;
      #1;
      chk("t4_valid_drop", b_valid, 0);
      chk("t4_bu_drop", b_bu, 5);
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("t4_pause_valid", b_valid, 0);
         chk("t4_pause_bu", b_bu, 5);
      end
      b_tx_en = 1'b1;
      #1;
      chk("t4_resume_pause_valid", b_valid, 0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk("t4_valid_post", b_valid, 1);
         chk("t4_bu_post", b_bu, 5 - i);
         cyc();
      end
      chk("t4_end_empty", b_empty, 1);

      // Reset in the middle of a word (overflow still set from the drain test)
      a_wr_valid = 1'b1; a_wr_data = 8'hCC; push_a(8'hCC);
      cyc();
      a_wr_valid = 1'b0;
      repeat (4) cyc();
      chk("t5_midbyte_valid", a_valid, 1);
      chk("t5_ovf_before", a_ovf, 1);
      rst = 1'b1;
      q_a.delete();
      q_b.delete();
      #1;
      chk("t5_rst_bu", a_bu, 0);
      chk("t5_rst_empty", a_empty, 1);
      chk("t5_rst_valid", a_valid, 0);
      chk("t5_rst_tx_bit", a_tx_bit, 0);
      chk("t5_rst_wr_ready", a_wr_ready, 1);
      chk("t5_rst_ovf", a_ovf, 0);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t5_post_valid", a_valid, 0);
         chk("t5_post_empty", a_empty, 1);
      end

      chk("final_q_a_drained", q_a.size(), 0);
      chk("final_q_b_drained", q_b.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gondola_tx_buffer.md
GONDOLA_TX_BUFFER -- requirements
Module: gondola_tx_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 128, FIFO depth in words (power of two, >=2).
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 serialises bit 0 first, 0 serialises bit DATA_W-1 first.
REQ-004 SHALL have local width BW = $clog2(DEPTH*DATA_W + DATA_W + 1).
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 wr_valid  input  1  write word request.
REQ-008 wr_data  input  DATA_W  word to store.
REQ-009 wr_ready  output  1  FIFO can accept a word this cycle.
REQ-010 tx_en  input  1  serial output enable; deassert pauses serialisation.
REQ-011 tx_bit  output  1  current serial bit.
REQ-012 tx_bit_valid  output  1  tx_bit is consumed this cycle.
REQ-013 bits_used  output  BW  bits held: FIFO words*DATA_W + unsent bits in shift register.
REQ-014 empty  output  1  bits_used == 0.
REQ-015 overflow  output  1  sticky: a write was dropped.
REQ-016 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-017 SHALL store words in a DEPTH-entry FIFO with wrapping read/write pointers and a word count 0..DEPTH.
REQ-018 wr_ready SHALL be combinationally (word count < DEPTH); a write occurs on a clock edge with wr_valid && wr_ready.
REQ-019 wr_valid && !wr_ready SHALL drop the word and set overflow on that edge; clr_ovf clears it; set wins over simultaneous clear.
REQ-020 FSM states SHALL be IDLE, LOAD, SHIFT, PAUSE.
REQ-021 IDLE: tx_bit_valid=0; if tx_en && word count>0, go to LOAD.
REQ-022 LOAD (one cycle): pop FIFO head into shift register, bit index=0, go to SHIFT; tx_bit_valid=0.
REQ-023 SHIFT: tx_bit_valid=1 and tx_bit = shift-register bit selected by LSB_FIRST and bit index; each cycle advances bit index by one.
REQ-024 On the last bit (index DATA_W-1) in SHIFT: if tx_en && word count>0, pop next word into shift register on the same edge and stay in SHIFT (no gap); otherwise go to IDLE.
REQ-025 SHIFT with tx_en=0 SHALL go to PAUSE without consuming a bit; tx_bit_valid=0 in PAUSE, bit index and shift register held; PAUSE returns to SHIFT when tx_en=1.
REQ-026 Each SHIFT cycle SHALL decrement bits_used by 1; each accepted write SHALL add DATA_W; both on one edge SHALL give a net +DATA_W-1.
REQ-027 Pop into shift register SHALL not change bits_used (bits move FIFO -> shift register).
REQ-028 Simultaneous write and pop on one edge SHALL both take effect; a write to a full FIFO on the pop edge SHALL still be refused (wr_ready uses pre-edge count).
REQ-029 Write to empty FIFO while IDLE and tx_en=1: LOAD the following cycle; first tx_bit_valid two edges after the write edge.
REQ-030 Maximum bits_used SHALL be DEPTH*DATA_W + DATA_W and SHALL never wrap.

Reset
REQ-031 rst SHALL force, asynchronously: FSM=IDLE, pointers and word count=0, bits_used=0, shift register=0, bit index=0, overflow=0.
REQ-032 During/after reset: wr_ready=1, empty=1, tx_bit=0, tx_bit_valid=0; reset mid-byte discards all stored and partial data.

Verification (DATA_W=8, DEPTH=4, LSB_FIRST=1 unless noted)
REQ-033 Write 8'hA5, tx_en=1 -> LOAD next cycle, then 8 valid bits 1,0,1,0,0,1,0,1; bits_used 8->0 by 1 per cycle; empty=1; IDLE.
REQ-034 Write 4 words, tx_en=0 -> wr_ready=0, bits_used=32; 5th write dropped, overflow=1; clr_ovf -> overflow=0.
REQ-035 Two words queued, tx_en=1 -> 16 consecutive tx_bit_valid cycles with no gap between words.
REQ-036 tx_en dropped after 3 bits of 8'hF0 (LSB_FIRST=0) -> tx_bit_valid=0, bits_used holds 5; resume sends 1,0,0,0,0 after 1,1,1.
REQ-037 Write on a SHIFT cycle -> bits_used net +7 that edge; assert rst mid-byte -> all outputs at reset values immediately.
